// File: rtl/isq_ctl.sv
// Issue-queue controller: circular head/tail queue with oldest-first issue,
// in-order retire of issued lines, and branch resolve / mispredict flush.
module isq_ctl #(
   parameter  int ENTRIES = 8,
   localparam int IW      = $clog2(ENTRIES)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               alloc_vld,
   input  logic               alloc_brn,
   output logic               alloc_rdy,
   output logic [IW-1:0]      alloc_idx,
   input  logic [ENTRIES-1:0] rdy_vec,
   input  logic               iss_stall,
   output logic               iss_vld,
   output logic [IW-1:0]      iss_idx,
   input  logic               brn_rslv,
   input  logic               brn_mis,
   input  logic [IW-1:0]      brn_idx,
   output logic [ENTRIES-1:0] lin_en,
   output logic [ENTRIES-1:0] lin_fls,
   output logic [ENTRIES-1:0] lin_clr_brn,
   output logic [ENTRIES-1:0] ent_val,
   output logic [IW:0]        cnt,
   output logic               full,
   output logic               empty
);

   logic [IW-1:0]      head, tail, idx, pick;
   logic [ENTRIES-1:0] val, brn, occ, fls, cand;
   logic               hit, mis_ok, acc, ret, rslv_ok, iss_go;

   // Age of a slot relative to head; wraps naturally for power-of-two ENTRIES.
   function automatic logic [IW-1:0] age(input logic [IW-1:0] a, input logic [IW-1:0] h);
      return a - h;
   endfunction

   assign ent_val   = val;
   assign alloc_idx = tail;
   assign full      = (cnt == (IW+1)'(ENTRIES));
   assign empty     = (cnt == '0);
   assign alloc_rdy = !full;

   always_comb begin
      occ = '0;
      fls = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         occ[i] = {1'b0, age(IW'(i), head)} < cnt;
         fls[i] = occ[i] && (age(IW'(i), head) > age(brn_idx, head));
      end
      mis_ok = !rst && brn_mis && occ[brn_idx];
      if (!mis_ok) fls = '0;

      cand = val & rdy_vec;
      hit  = 1'b0;
      pick = '0;
      idx  = '0;
      for (int k = 0; k < ENTRIES; k++) begin
         idx = head + IW'(k);
         if (!hit && cand[idx]) begin
            hit  = 1'b1;
            pick = idx;
         end
      end

      // Any mispredict, even an out-of-range one, freezes every other event.
      iss_vld = hit && !brn_mis && !rst;
      iss_idx = pick;
      iss_go  = iss_vld && !iss_stall;
      acc     = alloc_vld && !full && !brn_mis && !rst;
      ret     = !empty && !val[head] && !brn_mis && !rst;
      rslv_ok = brn_rslv && !brn_mis && !rst && occ[brn_idx] && brn[brn_idx];

      lin_en      = '0;
      lin_clr_brn = '0;
      if (acc)     lin_en[tail]         = 1'b1;
      if (rslv_ok) lin_clr_brn[brn_idx] = 1'b1;
      lin_fls = fls;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head <= '0;
         tail <= '0;
         cnt  <= '0;
         val  <= '0;
         brn  <= '0;
      end else if (mis_ok) begin
         val  <= val & ~fls;
         brn  <= brn & ~fls;
         tail <= brn_idx + IW'(1);
         cnt  <= {1'b0, age(brn_idx, head)} + (IW+1)'(1);
      end else if (!brn_mis) begin
         if (iss_go) val[pick] <= 1'b0;
         if (acc) begin
            val[tail] <= 1'b1;
            brn[tail] <= alloc_brn;
            tail      <= tail + IW'(1);
         end
         if (rslv_ok) brn[brn_idx] <= 1'b0;
         if (ret)     head <= head + IW'(1);
         cnt <= cnt + (IW+1)'(acc) - (IW+1)'(ret);
      end
   end

endmodule

// File: tb/tb_isq_ctl.sv
// Bench for isq_ctl: directed scenarios plus random traffic against a
// head/count reference model of the queue.
module tb_isq_ctl;

   logic       clk, rst;
   logic       alloc_vld, alloc_brn, alloc_rdy;
   logic [2:0] alloc_idx, iss_idx, brn_idx;
   logic [7:0] rdy_vec, lin_en, lin_fls, lin_clr_brn, ent_val;
   logic       iss_stall, iss_vld, brn_rslv, brn_mis, full, empty;
   logic [3:0] cnt;

   int nchk = 0, nfail = 0;
   int mh, mn;
   bit mv[8], mb[8];

   isq_ctl #(.ENTRIES(8)) dut (
      .clk(clk), .rst(rst),
      .alloc_vld(alloc_vld), .alloc_brn(alloc_brn), .alloc_rdy(alloc_rdy), .alloc_idx(alloc_idx),
      .rdy_vec(rdy_vec), .iss_stall(iss_stall), .iss_vld(iss_vld), .iss_idx(iss_idx),
      .brn_rslv(brn_rslv), .brn_mis(brn_mis), .brn_idx(brn_idx),
      .lin_en(lin_en), .lin_fls(lin_fls), .lin_clr_brn(lin_clr_brn),
      .ent_val(ent_val), .cnt(cnt), .full(full), .empty(empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock: compare against the model just after negedge, advance the model at posedge.
   task automatic cyc();
      int d, bi, s, t, ex_iss;
      bit occb, misok, acc, rsl, ret, hit;
      logic [7:0] efls, een, eclr, ev;
      #1;
      bi   = int'(brn_idx);
      d    = (bi - mh + 8) % 8;
      occb = d < mn;
      t    = (mh + mn) % 8;
      misok = !rst && brn_mis && occb;
      efls = '0;
      if (misok) for (int k = d + 1; k < mn; k++) efls[(mh + k) % 8] = 1'b1;
      hit = 0; ex_iss = 0;
      if (!rst && !brn_mis)
         for (int k = 0; k < mn; k++) begin
            s = (mh + k) % 8;
            if (!hit && mv[s] && rdy_vec[s]) begin hit = 1; ex_iss = s; end
         end
      acc = !rst && !brn_mis && alloc_vld && (mn < 8);
      rsl = !rst && !brn_mis && brn_rslv && occb && mb[bi];
      ret = !rst && !brn_mis && (mn > 0) && !mv[mh];
      een = '0;  if (acc) een[t] = 1'b1;
      eclr = '0; if (rsl) eclr[bi] = 1'b1;
      for (int i = 0; i < 8; i++) ev[i] = mv[i];

      chk("alloc_rdy", alloc_rdy, mn < 8);
      chk("alloc_idx", alloc_idx, t);
      chk("cnt", cnt, mn);
      chk("full", full, mn == 8);
      chk("empty", empty, mn == 0);
      chk("ent_val", ent_val, ev);
      chk("iss_vld", iss_vld, hit);
      if (hit) chk("iss_idx", iss_idx, ex_iss);
      chk("lin_en", lin_en, een);
      chk("lin_fls", lin_fls, efls);
      chk("lin_clr_brn", lin_clr_brn, eclr);

      @(posedge clk);
      if (rst) begin
         mh = 0; mn = 0;
         for (int i = 0; i < 8; i++) begin mv[i] = 0; mb[i] = 0; end
      end else if (misok) begin
         for (int k = d + 1; k < mn; k++) begin mv[(mh + k) % 8] = 0; mb[(mh + k) % 8] = 0; end
         mn = d + 1;
      end else if (!brn_mis) begin
         if (hit && !iss_stall) mv[ex_iss] = 0;
         if (acc) begin mv[t] = 1; mb[t] = alloc_brn; end
         if (rsl) mb[bi] = 0;
         if (ret) mh = (mh + 1) % 8;
         mn = mn + int'(acc) - int'(ret);
      end
      @(negedge clk);
   endtask

   task automatic idle();
      alloc_vld = 0; alloc_brn = 0; rdy_vec = '0; iss_stall = 0;
      brn_rslv = 0; brn_mis = 0; brn_idx = '0; rst = 0;
   endtask

   task automatic do_reset();
      idle(); rst = 1; cyc(); rst = 0;
   endtask

   task automatic alloc_n(input int n, input int brn_slot);
      for (int i = 0; i < n; i++) begin
         alloc_vld = 1;
         alloc_brn = ((mh + mn) % 8) == brn_slot;
         cyc();
      end
      alloc_vld = 0; alloc_brn = 0;
   endtask

   task automatic drain();
      int k = 0;
      alloc_vld = 0; rdy_vec = 8'hff;
      while (!empty && k < 40) begin cyc(); k++; end
      chk("drain_empty", empty, 1'b1);
      rdy_vec = '0;
   endtask

   initial begin
      mh = 0; mn = 0;
      for (int i = 0; i < 8; i++) begin mv[i] = 0; mb[i] = 0; end
      idle(); rst = 1;
      @(negedge clk);
      rst = 1; cyc(); cyc(); rst = 0;
      #1;
      chk("rst_alloc_rdy", alloc_rdy, 1'b1);
      chk("rst_empty", empty, 1'b1);
      chk("rst_full", full, 1'b0);
      chk("rst_alloc_idx", alloc_idx, 3'd0);

      // fill with nine requests, the last dropped
      alloc_vld = 1;
      for (int i = 0; i < 9; i++) begin
         #1;
         chk("fill_en", lin_en, (i < 8) ? (32'd1 << i) : 32'd0);
         cyc();
      end
      alloc_vld = 0;
      chk("fill_cnt", cnt, 4'd8);
      chk("fill_full", full, 1'b1);
      chk("fill_rdy", alloc_rdy, 1'b0);
      chk("fill_tail", alloc_idx, 3'd0);
      drain();

      // oldest-first issue and retire
      do_reset();
      alloc_n(3, -1);
      rdy_vec = 8'h06;
      #1 chk("old_idx1", iss_idx, 3'd1);
      cyc();
      #1 chk("old_idx2", iss_idx, 3'd2);
      cyc();
      #1 chk("old_none", iss_vld, 1'b0);
      chk("old_head", cnt, 4'd3);
      rdy_vec = 8'h01;
      #1 chk("old_idx0", iss_idx, 3'd0);
      cyc();
      rdy_vec = '0;
      cyc(); cyc(); cyc();
      chk("old_cnt0", cnt, 4'd0);
      chk("old_tail3", alloc_idx, 3'd3);

      // stall holds the offered issue
      alloc_n(1, -1);
      rdy_vec = 8'hff; iss_stall = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall_vld", iss_vld, 1'b1);
         chk("stall_idx", iss_idx, 3'd3);
         chk("stall_val", ent_val, 8'h08);
         cyc();
      end
      iss_stall = 0;
      cyc();
      chk("stall_rel", ent_val, 8'h00);
      rdy_vec = '0;

      // mispredict at slot 2 with a concurrent allocation
      do_reset();
      alloc_n(6, 2);
      brn_mis = 1; brn_idx = 3'd2; alloc_vld = 1; rdy_vec = 8'hff;
      #1;
      chk("mis_fls", lin_fls, 8'h38);
      chk("mis_en", lin_en, 8'h00);
      chk("mis_iss", iss_vld, 1'b0);
      cyc();
      idle();
      chk("mis_tail", alloc_idx, 3'd3);
      chk("mis_cnt", cnt, 4'd3);

      // wrap: head at 6 with four entries, branch sitting at slot 0
      do_reset();
      alloc_n(6, -1);
      drain();
      alloc_n(4, 0);
      brn_rslv = 1; brn_idx = 3'd0;
      #1 chk("wrap_clr", lin_clr_brn, 8'h01);
      cyc();
      brn_rslv = 0;
      brn_mis = 1; brn_idx = 3'd6; rst = 1; rdy_vec = 8'hff;
      #1;
      chk("rst_fls", lin_fls, 8'h00);
      chk("rst_iss", iss_vld, 1'b0);
      cyc();
      idle();
      #1;
      chk("rst2_cnt", cnt, 4'd0);
      chk("rst2_val", ent_val, 8'h00);
      chk("rst2_rdy", alloc_rdy, 1'b1);
      chk("rst2_idx", alloc_idx, 3'd0);

      // random traffic
      for (int n = 0; n < 800; n++) begin
         rst       = ($urandom_range(0, 99) == 0);
         alloc_vld = ($urandom_range(0, 2) != 0);
         alloc_brn = ($urandom_range(0, 2) == 0);
         rdy_vec   = 8'($urandom) & 8'($urandom);
         iss_stall = ($urandom_range(0, 4) == 0);
         brn_rslv  = ($urandom_range(0, 3) == 0);
         brn_mis   = ($urandom_range(0, 15) == 0);
         brn_idx   = 3'($urandom_range(0, 7));
         cyc();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
